// File: rtl/crpt_ctrl.sv
// crpt_ctrl: bus-mapped sequencer that fetches TRNG keys, launches cripto encryptions and captures ciphertext.
// Optional CRPT_IRQ_EN adds a level irq output and a STATUS[5] irq_en bit written via CTRL bit2.
module crpt_ctrl #(
  parameter int W           = 10,
  parameter int ENC_LAT     = 4,
  parameter int KEY_TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sel,
  input  logic         we,
  input  logic [4:0]   addr,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  input  logic [W-1:0] trng_out,
  input  logic         trng_ready,
  output logic [W-1:0] key,
  output logic [W-1:0] plaintext,
  input  logic [W-1:0] ciphertext,
  output logic         busy
`ifdef CRPT_IRQ_EN
  ,
  output logic         irq
`endif
);
  localparam int TMAX = (KEY_TIMEOUT > ENC_LAT) ? KEY_TIMEOUT : ENC_LAT;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  typedef enum logic [1:0] {IDLE, KEYWAIT, ENC} state_t;
  state_t r_state, w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [W-1:0] r_key, r_pt, r_ct;
  logic r_key_valid, r_done, r_timeout_err, r_reject_err;
  logic w_irq_en, w_ctrl_wr, w_pt_wr, w_key_req, w_launch, w_key_done, w_key_to, w_enc_done, w_reject;
  logic w_unused;
  assign w_unused   = &{1'b0, wdata, addr[1:0]};
  assign w_ctrl_wr  = sel & we & (addr[4:2] == 3'd1);
  assign w_pt_wr    = sel & we & (addr[4:2] == 3'd2);
  assign w_key_req  = w_ctrl_wr & wdata[0] & (r_state == IDLE);
  assign w_launch   = w_pt_wr & r_key_valid & (r_state == IDLE);
  assign w_key_done = (r_state == KEYWAIT) & trng_ready;
  // a TRNG pulse in the final wait cycle beats the timeout
  assign w_key_to   = (r_state == KEYWAIT) & ~trng_ready & (r_timer == TW'(KEY_TIMEOUT - 1));
  assign w_enc_done = (r_state == ENC) & (r_timer == TW'(ENC_LAT - 1));
  assign w_reject   = (w_ctrl_wr & wdata[0] & busy) | (w_pt_wr & ~w_launch);
  assign busy       = r_state != IDLE;
  assign key        = r_key;
  assign plaintext  = r_pt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    if (w_key_req) w_state_nxt = KEYWAIT;
    else if (w_launch) w_state_nxt = ENC;
    else if (w_key_done | w_key_to | w_enc_done) w_state_nxt = IDLE;
  end
  // flag clear comes first so that events in the same cycle still set their flags
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_timer       <= '0;
      r_key         <= '0;
      r_pt          <= '0;
      r_ct          <= '0;
      r_key_valid   <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_reject_err  <= 1'b0;
    end else begin
      if (busy) r_timer <= r_timer + TW'(1);
      if (w_ctrl_wr & wdata[1]) begin
        r_done        <= 1'b0;
        r_timeout_err <= 1'b0;
        r_reject_err  <= 1'b0;
      end
      if (w_reject) r_reject_err <= 1'b1;
      if (w_key_req) begin
        r_key_valid <= 1'b0;
        r_timer     <= '0;
      end
      if (w_launch) begin
        r_pt    <= wdata[W-1:0];
        r_done  <= 1'b0;
        r_timer <= '0;
      end
      if (w_key_done) begin
        r_key       <= trng_out;
        r_key_valid <= 1'b1;
      end
      if (w_key_to) r_timeout_err <= 1'b1;
      if (w_enc_done) begin
        r_ct   <= ciphertext;
        r_done <= 1'b1;
      end
    end
`ifdef CRPT_IRQ_EN
  logic r_irq_en;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_irq_en <= 1'b0;
    else if (w_ctrl_wr) r_irq_en <= wdata[2];
  assign w_irq_en = r_irq_en;
  assign irq      = r_irq_en & (r_done | r_timeout_err);
`else
  assign w_irq_en = 1'b0;
`endif
  assign rdata = (addr[4:2] == 3'd0) ? {26'd0, w_irq_en, r_reject_err, r_timeout_err, r_done, r_key_valid, busy} :
                 (addr[4:2] == 3'd3) ? 32'(r_ct) :
                 (addr[4:2] == 3'd4) ? 32'(r_key) : 32'd0;
endmodule

// File: tb/tb_crpt_ctrl.sv
// tb_crpt_ctrl: directed bench with a read scoreboard; each bus read queues its expected view and a negedge monitor checks it.
module tb_crpt_ctrl;
  logic clk = 1'b0, reset = 1'b0, sel = 1'b0, we = 1'b0, trng_ready = 1'b0, busy;
  logic [4:0] addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic [9:0] trng_out = '0, key, plaintext, ct_in = '0;
  logic irq;
  typedef struct {
    logic [31:0] d;
    logic        b;
    logic [9:0]  pt;
    logic        irq;
  } exp_t;
  exp_t sb[$];
  string nq[$];
  exp_t cur;
  string cur_n;
  logic [9:0] exp_pt = '0;
  logic exp_irq = 1'b0;
  int checks = 0, errors = 0;
  crpt_ctrl #(.W(10), .ENC_LAT(4), .KEY_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .trng_out(trng_out), .trng_ready(trng_ready), .key(key), .plaintext(plaintext),
    .ciphertext(ct_in), .busy(busy)
`ifdef CRPT_IRQ_EN
    , .irq(irq)
`endif
  );
`ifndef CRPT_IRQ_EN
  assign irq = 1'b0;
`endif
  always #5 clk = ~clk;
  always @(negedge clk)
    if (sel && !we) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: rdata=%h with no queued expectation", rdata);
      end else begin
        cur   = sb.pop_front();
        cur_n = nq.pop_front();
        if (rdata !== cur.d || busy !== cur.b || plaintext !== cur.pt || irq !== cur.irq) begin
          errors++;
          $display("FAIL %s: got rdata=%h busy=%b pt=%h irq=%b, want rdata=%h busy=%b pt=%h irq=%b",
                   cur_n, rdata, busy, plaintext, irq, cur.d, cur.b, cur.pt, cur.irq);
        end
      end
    end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick(1);
    sel = 1'b0; we = 1'b0;
  endtask
  task automatic rd(input logic [4:0] a, input logic [31:0] d, input logic b, input string n);
    exp_t e;
    e.d = d; e.b = b; e.pt = exp_pt; e.irq = exp_irq;
    sb.push_back(e);
    nq.push_back(n);
    sel = 1'b1; we = 1'b0; addr = a;
    tick(1);
    sel = 1'b0;
  endtask
  task automatic trng(input logic [9:0] v);
    trng_out = v; trng_ready = 1'b1;
    tick(1);
    trng_ready = 1'b0;
  endtask
  initial begin
    tick(3);
    reset = 1'b1;
    tick(1);
    rd(5'd0, 32'h00, 1'b0, "status_rst");
    rd(5'd12, 32'h0, 1'b0, "ct_rst");
    rd(5'd16, 32'h0, 1'b0, "key_rst");
    wr(5'd4, 32'h1);
    rd(5'd0, 32'h01, 1'b1, "status_keywait");
    tick(5);
    trng(10'h2A5);
    rd(5'd16, 32'h2A5, 1'b0, "key_loaded");
    rd(5'd0, 32'h02, 1'b0, "status_key");
    trng(10'h111);
    rd(5'd16, 32'h2A5, 1'b0, "key_ready_ignored");
    ct_in = 10'h3C3;
    wr(5'd8, 32'h155);
    exp_pt = 10'h155;
    for (int i = 0; i < 4; i++) rd(5'd0, 32'h03, 1'b1, "status_enc");
    rd(5'd0, 32'h06, 1'b0, "status_done");
    rd(5'd12, 32'h3C3, 1'b0, "ct_first");
    ct_in = 10'h0F0;
    wr(5'd8, 32'h0AA);
    exp_pt = 10'h0AA;
    wr(5'd8, 32'h3FF);
    for (int i = 0; i < 3; i++) rd(5'd0, 32'h13, 1'b1, "status_enc_reject");
    rd(5'd0, 32'h16, 1'b0, "status_done_reject");
    rd(5'd12, 32'h0F0, 1'b0, "ct_second");
    wr(5'd4, 32'h2);
    rd(5'd0, 32'h02, 1'b0, "status_cleared");
    wr(5'd8, 32'h001);
    tick(1);
    reset = 1'b0;
    exp_pt = '0;
    rd(5'd0, 32'h00, 1'b0, "status_in_reset");
    reset = 1'b1;
    rd(5'd0, 32'h00, 1'b0, "status_after_reset");
    rd(5'd12, 32'h0, 1'b0, "ct_after_reset");
    rd(5'd16, 32'h0, 1'b0, "key_after_reset");
    wr(5'd8, 32'h155);
    rd(5'd0, 32'h10, 1'b0, "status_nokey_reject");
    wr(5'd4, 32'h2);
    rd(5'd0, 32'h00, 1'b0, "status_reject_cleared");
    wr(5'd4, 32'h1);
    tick(14);
    rd(5'd0, 32'h01, 1'b1, "status_wait_15");
    rd(5'd0, 32'h01, 1'b1, "status_wait_16");
    rd(5'd0, 32'h08, 1'b0, "status_timeout");
    wr(5'd4, 32'h3);
    tick(15);
    trng(10'h1C7);
    rd(5'd0, 32'h02, 1'b0, "status_race_ready_wins");
    rd(5'd16, 32'h1C7, 1'b0, "key_race");
    wr(5'd4, 32'h1);
    wr(5'd4, 32'h1);
    rd(5'd0, 32'h11, 1'b1, "status_req_busy");
    wr(5'd4, 32'h2);
    rd(5'd0, 32'h01, 1'b1, "status_clear_busy");
    trng(10'h0C3);
    rd(5'd16, 32'h0C3, 1'b0, "key_third");
    rd(5'd0, 32'h02, 1'b0, "status_third");
    rd(5'd20, 32'h0, 1'b0, "unmapped_read");
    rd(5'd4, 32'h0, 1'b0, "ctrl_read");
    rd(5'd18, 32'h0C3, 1'b0, "key_unaligned");
`ifdef CRPT_IRQ_EN
    wr(5'd4, 32'h4);
    ct_in = 10'h3C3;
    wr(5'd8, 32'h155);
    exp_pt = 10'h155;
    tick(4);
    exp_irq = 1'b1;
    rd(5'd0, 32'h26, 1'b0, "status_irq");
    rd(5'd12, 32'h3C3, 1'b0, "ct_irq");
    wr(5'd4, 32'h6);
    exp_irq = 1'b0;
    rd(5'd0, 32'h22, 1'b0, "status_irq_cleared");
`endif
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick(1);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
